addsub_serial: RTL

Parametrised, multi-cycle adder/subtractor with a start/done handshake. Processes a W-bit operand pair D bits per clock, LSB digit first, with four modes: add, a−b, b−a and absolute difference. It is the area-scalable successor to the team's combinational 4-bit add/subtract block. It sits between an operand-register file and any consumer that can tolerate W/D-cycle latency in exchange for a D-bit-wide adder.

---
 rtl/addsub_serial_if.sv | 26 ++
 rtl/addsub_serial.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/addsub_serial_if.sv
// Handshake and data bundle for the digit-serial adder/subtractor.
// The requester (master) drives start and the operand/mode bus; the
// arithmetic unit (slave) returns the registered result and status flags.
interface addsub_serial_if #(
  parameter int W = 8
);
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [1:0]   mode;
  logic [W-1:0] s;
  logic         cout;
  logic         zero;
  logic         busy;
  logic         done;

  modport master (
    output start, a, b, mode,
    input  s, cout, zero, busy, done
  );

  modport slave (
    input  start, a, b, mode,
    output s, cout, zero, busy, done
  );
endinterface

// File: rtl/addsub_serial.sv
// Digit-serial adder/subtractor: W-bit operands processed D bits per clock,
// LSB digit first. Modes: 00 a+b, 01 a-b, 10 b-a, 11 |a-b|.
// Absolute difference takes a second serial pass (NEG) that negates the
// first-pass result when a < b. Results are committed to registered outputs
// together with a one-cycle done pulse.
module addsub_serial #(
  parameter int W = 8,
  parameter int D = 1
) (
  input  logic           clk,
  input  logic           rst,
  addsub_serial_if.slave bus
);

  localparam int N  = W / D;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (W < 2 || D < 1 || D > W || (W % D) != 0 || $bits(bus.a) != W) begin : g_bad_params
    $error("addsub_serial: W must be >= 2, 1 <= D <= W, W %% D == 0, and match the interface width");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    NEG  = 2'd2
  } state_t;

  state_t          state;
  logic [W-1:0]    op_x;
  logic [W-1:0]    op_y;
  logic [W-1:0]    res;
  logic            carry;
  logic [CW-1:0]   cnt;
  logic [1:0]      mode_q;
  logic [W-1:0]    s_q;
  logic            cout_q;
  logic            zero_q;
  logic            busy_q;
  logic            done_q;

  // Operand preload for a newly accepted request. The subtrahend is inverted
  // and the carry seeded with 1 so every subtraction reuses the same adder.
  logic [W-1:0]    ld_x;
  logic [W-1:0]    ld_y;
  logic            ld_carry;

  // One-digit adder shared by both passes; NEG feeds it ~res and zero so the
  // seeded carry completes the two's complement.
  logic [D-1:0]    dig_x;
  logic [D-1:0]    dig_y;
  logic [D:0]      dig_sum;
  logic [W+D-1:0]  res_cat;
  logic [W-1:0]    res_next;
  logic            last;
  logic            run_flag;

  // Select preload operands from the live request bus.
  always_comb begin
    ld_x     = bus.a;
    ld_y     = ~bus.b;
    ld_carry = 1'b1;
    case (bus.mode)
      2'b00: begin
        ld_y     = bus.b;
        ld_carry = 1'b0;
      end
      2'b10: begin
        ld_x = bus.b;
        ld_y = ~bus.a;
      end
      default: begin
        ld_x = bus.a;
        ld_y = ~bus.b;
      end
    endcase
  end

  // Current digit sum, next result shift-register value and the cout flag
  // a first-pass commit would record.
  always_comb begin
    dig_x    = (state == NEG) ? ~res[D-1:0] : op_x[D-1:0];
    dig_y    = (state == NEG) ? '0 : op_y[D-1:0];
    dig_sum  = {1'b0, dig_x} + {1'b0, dig_y} + {{D{1'b0}}, carry};
    res_cat  = {dig_sum[D-1:0], res};
    res_next = res_cat[W+D-1:D];
    last     = (cnt == LAST);
    case (mode_q)
      2'b00:   run_flag = dig_sum[D];
      2'b11:   run_flag = 1'b0;
      default: run_flag = ~dig_sum[D];
    endcase
  end

  // Control FSM and serial datapath; a commit edge may accept the next
  // request directly so a held start issues back-to-back operations.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      op_x   <= '0;
      op_y   <= '0;
      res    <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      mode_q <= 2'b00;
      s_q    <= '0;
      cout_q <= 1'b0;
      zero_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_x   <= ld_x;
            op_y   <= ld_y;
            carry  <= ld_carry;
            cnt    <= '0;
            mode_q <= bus.mode;
            state  <= RUN;
            busy_q <= 1'b1;
          end
        end

        RUN, NEG: begin
          res   <= res_next;
          op_x  <= op_x >> D;
          op_y  <= op_y >> D;
          carry <= dig_sum[D];
          cnt   <= cnt + 1'b1;
          if (last) begin
            if (state == RUN && mode_q == 2'b11 && !dig_sum[D]) begin
              // a < b in absolute-difference mode: negate the result serially.
              state <= NEG;
              carry <= 1'b1;
              cnt   <= '0;
            end else begin
              s_q    <= res_next;
              zero_q <= (res_next == '0);
              cout_q <= (state == NEG) ? 1'b1 : run_flag;
              done_q <= 1'b1;
              if (bus.start) begin
                op_x   <= ld_x;
                op_y   <= ld_y;
                carry  <= ld_carry;
                cnt    <= '0;
                mode_q <= bus.mode;
                state  <= RUN;
                busy_q <= 1'b1;
              end else begin
                state  <= IDLE;
                busy_q <= 1'b0;
              end
            end
          end
        end

        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.s    = s_q;
  assign bus.cout = cout_q;
  assign bus.zero = zero_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule
